// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: holds the rPLL in reset, waits for a stable LOCK, then asserts pll_ready; retries, relocks, latches fault
module pll_lock_sequencer #(
  parameter int RESET_CYCLES  = 16,
  parameter int LOCK_TIMEOUT  = 27000,
  parameter int STABLE_CYCLES = 256,
  parameter int MAX_RETRIES   = 3,
  parameter int CNT_W         = 16,
  parameter int RETRY_W       = 2
) (
  input  logic               clkin,
  input  logic               rst_n,
  input  logic               pll_lock,
  input  logic               relock_req,
  output logic               pll_reset,
  output logic               pll_ready,
  output logic               lock_lost,
  output logic               fault,
  output logic [RETRY_W-1:0] retry_count
);
  typedef enum logic [2:0] {RESET_HOLD, WAIT_LOCK, STABILIZE, READY, FAULT} state_e;
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic lost_q, lost_d, sync1_q, sync2_q;
  logic lock_s, hold_end, wait_end, stab_end, retry_max;
  assign lock_s    = sync2_q;
  assign hold_end  = cnt_q == CNT_W'(RESET_CYCLES - 1);
  assign wait_end  = cnt_q == CNT_W'(LOCK_TIMEOUT - 1);
  assign stab_end  = cnt_q == CNT_W'(STABLE_CYCLES - 1);
  assign retry_max = retry_q == RETRY_W'(MAX_RETRIES);
  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      state_q <= RESET_HOLD;
      cnt_q   <= '0;
      retry_q <= '0;
      lost_q  <= 1'b0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      lost_q  <= lost_d;
      sync1_q <= pll_lock;
      sync2_q <= sync1_q;
    end
  end
  // cnt_d defaults to zero so every state change clears the counter
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    retry_d = retry_q;
    lost_d  = 1'b0;
    case (state_q)
      RESET_HOLD: begin
        state_d = hold_end ? WAIT_LOCK : RESET_HOLD;
        cnt_d   = hold_end ? '0 : cnt_q + 1'b1;
      end
      WAIT_LOCK: begin
        if (relock_req) begin
          state_d = RESET_HOLD;
          retry_d = '0;
        end else if (lock_s) begin
          state_d = STABILIZE;
        end else if (wait_end) begin
          state_d = retry_max ? FAULT : RESET_HOLD;
          retry_d = retry_max ? retry_q : retry_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STABILIZE: begin
        if (relock_req) begin
          state_d = RESET_HOLD;
          retry_d = '0;
        end else if (!lock_s) begin
          state_d = WAIT_LOCK;
        end else if (stab_end) begin
          state_d = READY;
          retry_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      READY: begin
        state_d = (relock_req || !lock_s) ? RESET_HOLD : READY;
        lost_d  = !relock_req && !lock_s;
      end
      FAULT: begin
        state_d = relock_req ? RESET_HOLD : FAULT;
        retry_d = relock_req ? '0 : retry_q;
      end
      default: state_d = RESET_HOLD;
    endcase
  end
  assign pll_reset   = !(state_q inside {WAIT_LOCK, STABILIZE, READY});
  assign pll_ready   = state_q == READY;
  assign fault       = state_q == FAULT;
  assign lock_lost   = lost_q;
  assign retry_count = retry_q;
endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer: directed plus random stimulus checked against a countdown-based phase model
module tb_pll_lock_sequencer;
  localparam int RC = 4, LT = 20, SC = 8, MR = 2;
  logic clkin = 1'b0, rst_n = 1'b0, pll_lock = 1'b0, relock_req = 1'b0;
  logic pll_reset, pll_ready, lock_lost, fault;
  logic [1:0] retry_count;
  int checks = 0, errors = 0;
  int mode = 0, left = RC, retries = 0;
  bit lost = 1'b0;
  bit [1:0] pipe = 2'b00;
  pll_lock_sequencer #(
    .RESET_CYCLES(RC), .LOCK_TIMEOUT(LT), .STABLE_CYCLES(SC),
    .MAX_RETRIES(MR), .CNT_W(16), .RETRY_W(2)
  ) dut (
    .clkin(clkin), .rst_n(rst_n), .pll_lock(pll_lock), .relock_req(relock_req),
    .pll_reset(pll_reset), .pll_ready(pll_ready), .lock_lost(lock_lost),
    .fault(fault), .retry_count(retry_count)
  );
  always #5 clkin = ~clkin;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask
  // mode: 0 hold, 1 wait-lock, 2 stabilize, 3 ready, 4 fault; left counts remaining cycles in the phase
  task automatic model(input bit r, input bit rl, input bit lk);
    bit ls;
    if (!r) begin
      mode = 0; left = RC; retries = 0; lost = 1'b0; pipe = 2'b00;
      return;
    end
    ls = pipe[1];
    pipe = {pipe[0], lk};
    lost = 1'b0;
    if (rl && mode != 0) begin
      mode = 0; left = RC; retries = 0;
      return;
    end
    case (mode)
      0: begin
        left--;
        if (left == 0) begin mode = 1; left = LT; end
      end
      1: begin
        if (ls) begin
          mode = 2; left = SC;
        end else begin
          left--;
          if (left == 0) begin
            if (retries == MR) mode = 4;
            else begin retries++; mode = 0; left = RC; end
          end
        end
      end
      2: begin
        if (!ls) begin
          mode = 1; left = LT;
        end else begin
          left--;
          if (left == 0) begin mode = 3; retries = 0; end
        end
      end
      3: if (!ls) begin mode = 0; left = RC; lost = 1'b1; end
      default: ;
    endcase
  endtask
  task automatic step(input bit r, input bit rl, input bit lk);
    @(negedge clkin);
    rst_n = r; relock_req = rl; pll_lock = lk;
    @(posedge clkin);
    model(r, rl, lk);
    #1;
    check("pll_reset", 32'(pll_reset), 32'(mode == 0 || mode == 4));
    check("pll_ready", 32'(pll_ready), 32'(mode == 3));
    check("fault", 32'(fault), 32'(mode == 4));
    check("lock_lost", 32'(lock_lost), 32'(lost));
    check("retry_count", 32'(retry_count), 32'(retries));
  endtask
  task automatic run(input int n, input bit lk);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, lk);
  endtask
  initial begin
    int len;
    bit lk;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    run(14, 1'b0);
    run(20, 1'b1);
    check("ready_after_lock", 32'(pll_ready), 32'd1);
    run(100, 1'b0);
    check("fault_after_retries", 32'(fault), 32'd1);
    step(1'b1, 1'b1, 1'b0);
    run(10, 1'b0);
    run(14, 1'b1);
    run(3, 1'b0);
    run(30, 1'b1);
    check("ready_after_dropout", 32'(pll_ready), 32'd1);
    run(3, 1'b0);
    run(10, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    check("reset_wins", 32'(pll_reset), 32'd1);
    for (int s = 0; s < 80; s++) begin
      lk = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 4) == 0) ? $urandom_range(60, 110) : $urandom_range(1, 30);
      for (int i = 0; i < len; i++)
        step(1'($urandom_range(0, 299) != 0), 1'($urandom_range(0, 39) == 0), lk);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
